mod_mul_serial: RTL and testbench
=================================

Name: mod_mul_serial

Overview:
- Sequential modular multiplier: prod = x*y mod P, for the secp256k1 field arithmetic path.
- Consumes the modular add/double step (the combinational mod_add function) and iterates it bit-serially, MSB first, using the interleaved double-and-add method.
- Sits directly downstream of mod_add and is the next building block toward the point-add/point-double datapath.
- One multiplier bit is processed per clock, behind a start/busy/done handshake.

Parameters:
- WIDTH, 256, operand/result width in bits.
- P, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, field modulus (secp256k1 prime).
- CNT_W, 8, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  multiplicand; must be < P (see optional feature).
- y  input  WIDTH  multiplier; must be < P.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when prod is updated.
- prod  output  WIDTH  result; holds its value until the next completion or reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, done=0, prod=0.
  - Internal x_r, y_r, r and cnt cleared.
  - Applies mid-operation too: the operation in flight is abandoned and no done is produced.
- States:
  - IDLE: busy=0. On start=1 at edge E0:
    - latch x_r=x, y_r=y;
    - r=0, cnt=WIDTH-1;
    - go to RUN.
  - RUN: busy=1. Each edge:
    - d = 2r (WIDTH+1 bits); if d >= P then d = d - P.
    - if y_r[cnt]=1: s = d + x_r (WIDTH+1 bits); if s >= P then s = s - P; else s = d.
    - r = s.
    - if cnt==0: prod = s, done=1, state=IDLE. Otherwise cnt = cnt-1.
- Latency:
  - Start accepted at E0; iterations on edges E1..E_WIDTH.
  - done=1 and prod valid after edge E_WIDTH, i.e. 256 cycles for WIDTH=256.
  - busy=1 from after E0 until edge E_WIDTH, where it drops to 0.
- done is high for exactly one cycle and is cleared at the next edge.
- Arithmetic:
  - All intermediates are WIDTH+1 bits, so no carry is lost.
  - A single conditional subtract per step is sufficient because r < P and x_r < P.
  - The invariant r < P holds at every step.
- Boundaries:
  - start=1 while busy=1: ignored; latched operands are unchanged.
  - start=1 in the done cycle (state is IDLE): accepted, giving back-to-back operation with no bubble.
  - x or y changing during RUN: no effect.
  - y=0 or x=0: full latency, prod=0.
  - Operands >= P without the optional feature: result undefined, no flag raised.

Optional Feature:
- Macro: MOD_MUL_SERIAL_INPUT_REDUCE_EN.
- Defined:
  - At start acceptance, x_r = (x >= P) ? x - P : x, and y_r likewise, computed combinationally in the E0 cycle.
  - Latency is unchanged.
  - Any WIDTH-bit input gives a correct result, since 2^256 < 2P.
- Undefined:
  - Operands are latched raw; the "< P" input contract applies.
  - No extra comparators are synthesized.

Test Plan:
- x=2, y=3, start pulse -> busy high 256 cycles; done pulse exactly 256 cycles after start edge; prod=6.
- x=P-1, y=P-1 -> prod=1. Then x=P-1, y=2 -> prod=P-2 (…FFFFFC2D).
- x=1, y=256'h9A3F2D7C8B1E6F4A5C9D2E0F8A7B1C2D3E8F9A123456789ABCDEF0123456789 -> prod=y. Then x=0, same y -> prod=0 with full latency.
- Start op (x=2, y=3); drive reset low at cycle 100 for 2 cycles -> busy=0, done=0, prod=0 immediately (asynchronous); no done pulse later. New start x=5, y=7 -> prod=35 after 256 cycles.
- Start x=2, y=3; at cycle 50 assert start with x=4, y=4 -> ignored, prod=6. Assert start with x=3, y=3 in the done cycle -> second done exactly 256 cycles later, prod=9.
- With MOD_MUL_SERIAL_INPUT_REDUCE_EN: x=P+5, y=1 -> prod=5; x=P+2, y=P+3 -> prod=6.

Source files
------------

// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier prod = x*y mod P (MSB-first interleaved double-and-add), one bit per clock.
// Optional input reduction of operands >= P is enabled by defining MOD_MUL_SERIAL_INPUT_REDUCE_EN.
module mod_mul_serial #(
  parameter int               WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The one-bit carry slot keeps a+b exact, so one conditional subtract restores a+b < P.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, P}) begin
      sum = sum - {1'b0, P};
    end else begin
      sum = sum;
    end
    return sum[WIDTH-1:0];
  endfunction

`ifdef MOD_MUL_SERIAL_INPUT_REDUCE_EN
  // Any WIDTH-bit value is below 2P, so a single subtract fully reduces it.
  function automatic logic [WIDTH-1:0] reduce_in(input logic [WIDTH-1:0] a);
    return (a >= P) ? (a - P) : a;
  endfunction
`endif

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   x_r, x_s;
  logic [WIDTH-1:0]   y_r, y_s;
  logic [WIDTH-1:0]   r_r, r_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [WIDTH-1:0]   prod_r, prod_s;
  logic               done_r, done_s;
  logic               busy_r, busy_s;
  logic [WIDTH-1:0]   dbl_s;
  logic [WIDTH-1:0]   step_s;

  // One double-and-add step on the current accumulator.
  always_comb begin
    dbl_s = mod_add(r_r, r_r);
    if (y_r[cnt_r]) begin
      step_s = mod_add(dbl_s, x_r);
    end else begin
      step_s = dbl_s;
    end
  end

  // Next-state and next-register computation for the IDLE/RUN controller.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    r_s     = r_r;
    cnt_s   = cnt_r;
    prod_s  = prod_r;
    done_s  = 1'b0;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (start) begin
`ifdef MOD_MUL_SERIAL_INPUT_REDUCE_EN
          x_s = reduce_in(x);
          y_s = reduce_in(y);
`else
          x_s = x;
          y_s = y;
`endif
          r_s     = {WIDTH{1'b0}};
          cnt_s   = CNT_W'(WIDTH - 1);
          state_s = RUN;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      RUN: begin
        r_s = step_s;
        if (cnt_r == {CNT_W{1'b0}}) begin
          prod_s  = step_s;
          done_s  = 1'b1;
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          cnt_s  = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      x_r     <= {WIDTH{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      r_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      prod_r  <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      r_r     <= r_s;
      cnt_r   <= cnt_s;
      prod_r  <= prod_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign prod = prod_r;

endmodule

// File: tb/tb_mod_mul_serial.sv
// Scoreboard bench for mod_mul_serial: stimulus pushes expected product and done cycle, a monitor checks each done.
// Define MOD_MUL_SERIAL_INPUT_REDUCE_EN to also exercise operand reduction.
module tb_mod_mul_serial;

  localparam logic [255:0] P  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] YV = 256'h9A3F2D7C8B1E6F4A5C9D2E0F8A7B1C2D3E8F9A123456789ABCDEF0123456789;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [255:0] x = '0;
  logic [255:0] y = '0;
  logic         busy;
  logic         done;
  logic [255:0] prod;

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  logic [255:0] exp_q[$];
  int           cyc_q[$];

  mod_mul_serial dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest scoreboard entry in value and timing.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending operation", cyc);
      end else begin
        logic [255:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("prod", prod, e);
        chk("done_cycle", 256'(cyc), 256'(c));
      end
    end
  end

  // Drive a start at the current negedge; the accepting edge is the next posedge.
  task automatic drive(input logic [255:0] a, input logic [255:0] b, input logic [255:0] e);
    x = a;
    y = b;
    start = 1'b1;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 257);
  endtask

  task automatic issue(input logic [255:0] a, input logic [255:0] b, input logic [255:0] e);
    @(negedge clk);
    drive(a, b, e);
    @(negedge clk);
    start = 1'b0;
    x = '1;
    y = '1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0 expected done pulse", name);
    end
  endtask

  initial begin
    int nbusy;
    bit seen;
    #1;
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_prod", prod, 256'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 2*3, counting busy cycles until done
    @(negedge clk);
    drive(256'd2, 256'd3, 256'd6);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 256'(busy), 256'd1);
    nbusy = busy ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    chk("done_seen", 256'(seen), 256'd1);
    chk("busy_cycles", 256'(nbusy), 256'd256);
    chk("busy_at_done", 256'(busy), 256'd0);
    @(negedge clk);
    chk("done_one_cycle", 256'(done), 256'd0);
    chk("prod_hold", prod, 256'd6);

    issue(P - 256'd1, P - 256'd1, 256'd1);
    wait_idle("pm1_sq");
    issue(P - 256'd1, 256'd2, P - 256'd2);
    wait_idle("pm1_x2");
    issue(256'd1, YV, YV);
    wait_idle("one_y");
    issue(256'd0, YV, 256'd0);
    wait_idle("zero_y");

    // Reset mid-operation abandons it with no done
    issue(256'd2, 256'd3, 256'd6);
    repeat (98) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 256'(busy), 256'd0);
    chk("midrst_done", 256'(done), 256'd0);
    chk("midrst_prod", prod, 256'd0);
    exp_q.delete();
    cyc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    chk("no_done_after_rst", prod, 256'd0);
    issue(256'd5, 256'd7, 256'd35);
    wait_idle("after_rst");

    // Start while busy is ignored; start in the done cycle is accepted
    issue(256'd2, 256'd3, 256'd6);
    repeat (48) @(negedge clk);
    x = 256'd4;
    y = 256'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_first");
    drive(256'd3, 256'd3, 256'd9);
    @(negedge clk);
    start = 1'b0;
    x = '0;
    y = '0;
    wait_idle("b2b_second");

`ifdef MOD_MUL_SERIAL_INPUT_REDUCE_EN
    issue(P + 256'd5, 256'd1, 256'd5);
    wait_idle("reduce_x");
    issue(P + 256'd2, P + 256'd3, 256'd6);
    wait_idle("reduce_xy");
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
